// File: rtl/onehot_decoder_seq.sv
// Registered SEL_W-to-OUT_N one-hot decoder with a scan mode that walks one bit across every output.
// Latency: 1 cycle per decode; a scan takes OUT_N outputs plus one done cycle. No backpressure, one request per cycle in IDLE.
// ONEHOT_DECODER_ACTIVE_LOW_EN: when defined, y is driven one-cold (all ones when idle).
module onehot_decoder_seq #(
    parameter int SEL_W = 4,
    parameter int OUT_N = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    input  logic             scan_start,
    output logic [OUT_N-1:0] y,
    output logic             valid,
    output logic             busy,
    output logic             scan_done,
    output logic             err
);

    typedef enum logic {IDLE, SCAN} state_t;

    localparam logic [SEL_W-1:0] CNT_LAST = SEL_W'(OUT_N - 1);
    localparam logic [OUT_N-1:0] ONE      = OUT_N'(1);

    state_t           state_q;
    logic [SEL_W-1:0] cnt_q;
    logic [OUT_N-1:0] y_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic             last_q;
    logic             sel_ok;

    // Compare at 32 bits so OUT_N == 2**SEL_W does not truncate to zero.
    assign sel_ok = (32'(sel) < OUT_N);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            y_q     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (scan_start) begin
                        state_q <= SCAN;
                        cnt_q   <= '0;
                        last_q  <= 1'b0;
                    end else if (en) begin
                        if (sel_ok) begin
                            y_q     <= ONE << sel;
                            valid_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (last_q) begin
                        done_q  <= 1'b1;
                        last_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        y_q     <= ONE << cnt_q;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        last_q  <= (cnt_q == CNT_LAST);
                        // Saturate at the terminal index instead of wrapping.
                        if (cnt_q != CNT_LAST) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ONEHOT_DECODER_ACTIVE_LOW_EN
    assign y = ~y_q;
`else
    assign y = y_q;
`endif
    assign valid     = valid_q;
    assign busy      = busy_q;
    assign scan_done = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Bench for onehot_decoder_seq: a 16-output and a 12-output instance against a schedule-based reference model.
module tb_onehot_decoder_seq;

    typedef struct packed {
        logic [15:0] y;
        logic        v;
        logic        b;
        logic        d;
        logic        e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en16 = 1'b0, ss16 = 1'b0, en12 = 1'b0, ss12 = 1'b0;
    logic [3:0]  sel16 = '0, sel12 = '0;
    logic [15:0] y16;
    logic [11:0] y12;
    logic        v16, b16, d16, e16, v12, b12, d12, e12;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: a table of pre-scheduled outputs per instance; idle when drained.
    exp_t sched [2][0:16];
    int   head  [2];
    int   tail  [2];

    always #5 clk = ~clk;

    onehot_decoder_seq #(.SEL_W(4), .OUT_N(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .en(en16), .sel(sel16), .scan_start(ss16),
        .y(y16), .valid(v16), .busy(b16), .scan_done(d16), .err(e16)
    );

    onehot_decoder_seq #(.SEL_W(4), .OUT_N(12)) dut12 (
        .clk(clk), .rst_n(rst_n), .en(en12), .sel(sel12), .scan_start(ss12),
        .y(y12), .valid(v12), .busy(b12), .scan_done(d12), .err(e12)
    );

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            head[d] = 0;
            tail[d] = 0;
        end
    endtask

    task automatic model_step(input int d, input int n, input logic en, input logic [3:0] sel,
                              input logic ss, output exp_t e);
        e = '0;
        if (head[d] < tail[d]) begin
            e = sched[d][head[d]];
            head[d]++;
        end else begin
            head[d] = 0;
            tail[d] = 0;
            if (ss) begin
                for (int i = 0; i < n; i++) begin
                    sched[d][i]   = '0;
                    sched[d][i].y = 16'(2 ** i);
                    sched[d][i].v = 1'b1;
                    sched[d][i].b = 1'b1;
                end
                sched[d][n]   = '0;
                sched[d][n].d = 1'b1;
                tail[d] = n + 1;
            end else if (en) begin
                if (int'(sel) < n) begin
                    e.y = 16'(2 ** int'(sel));
                    e.v = 1'b1;
                end else begin
                    e.e = 1'b1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic check_dut(input int d, input exp_t e);
        logic [15:0] yo, ye, mask;
        string       nm;
        nm   = (d == 0) ? "n16" : "n12";
        mask = (d == 0) ? 16'hFFFF : 16'h0FFF;
        yo   = (d == 0) ? y16 : {4'b0, y12};
        ye   = e.y;
`ifdef ONEHOT_DECODER_ACTIVE_LOW_EN
        ye = ~e.y & mask;
`endif
        chk({nm, "_y"}, yo & mask, ye);
        chk({nm, "_valid"}, 16'((d == 0) ? v16 : v12), 16'(e.v));
        chk({nm, "_busy"},  16'((d == 0) ? b16 : b12), 16'(e.b));
        chk({nm, "_done"},  16'((d == 0) ? d16 : d12), 16'(e.d));
        chk({nm, "_err"},   16'((d == 0) ? e16 : e12), 16'(e.e));
    endtask

    // One clock: model consumes the inputs seen at the edge, outputs checked 1 time unit later.
    task automatic tick();
        exp_t e0, e1;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
            e0 = '0;
            e1 = '0;
        end else begin
            model_step(0, 16, en16, sel16, ss16, e0);
            model_step(1, 12, en12, sel12, ss12, e1);
        end
        #1;
        check_dut(0, e0);
        check_dut(1, e1);
    endtask

    // Reset asserted between edges must clear outputs without a clock edge.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_dut(0, '0);
        check_dut(1, '0);
        tick();
        rst_n = 1'b1;
    endtask

    task automatic idle_inputs();
        en16 = 1'b0; ss16 = 1'b0; sel16 = '0;
        en12 = 1'b0; ss12 = 1'b0; sel12 = '0;
    endtask

    initial begin
        model_reset();
        #1;
        check_dut(0, '0);
        check_dut(1, '0);
        tick();
        tick();
        rst_n = 1'b1;

        // Decode every index back-to-back, then drop en.
        for (int i = 0; i < 16; i++) begin
            en16 = 1'b1; sel16 = 4'(i);
            en12 = 1'(i % 2); sel12 = 4'($urandom_range(0, 15));
            tick();
        end
        idle_inputs();
        tick();

        // Asynchronous reset while y holds bit 10.
        en16 = 1'b1; sel16 = 4'd10;
        tick();
        idle_inputs();
        async_reset();

        // Full scan with en/sel=3 and stray scan_start ignored mid-walk.
        ss16 = 1'b1; ss12 = 1'b1;
        tick();
        for (int i = 0; i < 17; i++) begin
            ss16 = 1'($urandom_range(0, 1)); ss12 = 1'b0;
            en16 = 1'b1; sel16 = 4'd3;
            en12 = 1'b1; sel12 = 4'd3;
            tick();
        end
        idle_inputs();
        tick();
        tick();

        // scan_start wins over a same-cycle decode request.
        en16 = 1'b1; sel16 = 4'd5; ss16 = 1'b1;
        tick();
        idle_inputs();
        for (int i = 0; i < 18; i++) tick();

        // Out-of-range and top index on the 12-output instance, then its scan.
        en12 = 1'b1; sel12 = 4'd13;
        tick();
        sel12 = 4'd11;
        tick();
        en12 = 1'b0; ss12 = 1'b1;
        tick();
        ss12 = 1'b0;
        for (int i = 0; i < 14; i++) tick();

        // Reset in the middle of a scan, then restart from bit 0.
        ss16 = 1'b1;
        tick();
        ss16 = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        async_reset();
        for (int i = 0; i < 3; i++) tick();
        ss16 = 1'b1;
        tick();
        ss16 = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        for (int i = 0; i < 16; i++) tick();

        // Random traffic on both instances.
        for (int i = 0; i < 400; i++) begin
            en16 = 1'($urandom_range(0, 1)); sel16 = 4'($urandom_range(0, 15));
            ss16 = ($urandom_range(0, 19) == 0);
            en12 = 1'($urandom_range(0, 1)); sel12 = 4'($urandom_range(0, 15));
            ss12 = ($urandom_range(0, 19) == 0);
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 20; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/onehot_decoder_seq.md
Name: onehot_decoder_seq

Overview:
- Parametrised, registered N-to-M one-hot decoder that generalises the fixed 4-to-16 decoder; it is the register-file write-enable generator.
- Normal mode: decodes `sel` into a one-hot `y`, one cycle after `en`.
- Scan mode: walks the one-hot bit across every output, one per cycle. Used to clear or initialise the register file after boot.
- Sits between the control unit and the register-file write ports.

Parameters:
- SEL_W, 4, width of the select input.
- OUT_N, 16, number of outputs; legal range 2 ≤ OUT_N ≤ 2**SEL_W.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  decode request, sampled each cycle in IDLE
- sel  input  SEL_W  index to decode
- scan_start  input  1  single-cycle request to start a full output walk
- y  output  OUT_N  registered one-hot output
- valid  output  1  y holds a decoded value this cycle
- busy  output  1  scan in progress
- scan_done  output  1  one-cycle pulse after the last scan output
- err  output  1  one-cycle pulse: en with sel ≥ OUT_N

Behaviour:
- Reset (rst_n=0, asynchronous, any state including mid-scan):
  - state=IDLE, scan counter=0.
  - y=0, valid=0, busy=0, scan_done=0, err=0.
  - Release is synchronous to the next clk edge.
- State machine: IDLE, SCAN.
- IDLE:
  - en=1 and sel<OUT_N: next edge y=1<<sel, valid=1. Latency exactly 1 cycle; back-to-back requests give one decode per cycle.
  - en=1 and sel≥OUT_N: next edge y=0, valid=0, err=1 for one cycle.
  - en=0: next edge y=0, valid=0.
  - scan_start=1: transition to SCAN and load counter=0. The first scan output appears on the next edge.
  - scan_start takes priority over en in the same cycle: the en request is dropped, with no err or valid from it.
- SCAN:
  - Each edge: y=1<<cnt, valid=1, busy=1, then cnt increments.
  - en and scan_start are ignored; no err is generated.
  - After the edge that presents y bit OUT_N-1, the next edge gives y=0, valid=0, busy=0, scan_done=1 for one cycle, and state returns to IDLE.
  - A scan therefore occupies OUT_N+1 cycles: OUT_N outputs plus one done cycle.
  - An en or scan_start asserted in the done cycle is accepted as in IDLE.
- Counter:
  - Width SEL_W, no wrap-around.
  - Terminal compare against OUT_N-1, so non-power-of-two OUT_N works.
- Invariants:
  - y is always zero-hot or one-hot.
  - valid=1 iff y≠0 (in active-high polarity).
  - busy=1 only in SCAN.
  - scan_done and err are never high in the same cycle.

Optional Feature:
- Macro: ONEHOT_DECODER_ACTIVE_LOW_EN.
- Defined: y is driven inverted (one-cold). Reset and idle value of y is all ones; a decoded or scan output has exactly one 0. valid, busy, scan_done and err are unchanged, active-high.
- Undefined: y is active-high as described above.

Test Plan:
- SEL_W=4, OUT_N=16: reset, then en=1 with sel stepped 0..15 on consecutive cycles.
  - Each cycle y=0x0001,0x0002,…,0x8000 one cycle later, valid=1 throughout.
  - Then en=0 gives y=0x0000, valid=0.
- Assert rst_n=0 asynchronously between edges while y=0x0400 → y=0, valid=0 immediately, without waiting for a clock edge.
- scan_start=1 for one cycle (OUT_N=16):
  - busy=1 for 16 cycles with y=0x0001…0x8000.
  - Then scan_done=1 for one cycle with y=0, busy=0.
  - en=1, sel=3 mid-scan has no effect.
- en=1, sel=5 and scan_start=1 in the same cycle → scan runs, the first output is y=0x0001, and 0x0020 never appears.
- OUT_N=12: en=1, sel=13 → y=0, valid=0, err=1 for one cycle.
  - en=1, sel=11 → y=0x800.
  - A scan ends after y=0x800 with scan_done.
- Reset asserted at scan step 7 (y=0x0080) → IDLE, busy=0, no scan_done.
  - A following scan_start restarts at y=0x0001.
  - With ONEHOT_DECODER_ACTIVE_LOW_EN defined, repeat the first scenario: y=0xFFFE…0x7FFF, and the reset value is 0xFFFF.
